// File: rtl/sha512_mode_hash.sv
// SHA-512 family hash controller: mode IV selection, multi-block chaining and digest
// truncation around an iterative one-round-per-cycle SHA-512 compression core.

module sha512_core (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [1023:0] i_data,
    input  logic [511:0]  i_vin,
    output logic [511:0]  o_vout,
    output logic          o_done
);
    localparam logic [63:0] K [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    logic [0:15][63:0] w;
    logic [0:15][63:0] w_next;
    logic [0:7][63:0]  hin;
    logic [0:7][63:0]  wv;
    logic [0:7][63:0]  wv_next;
    logic [0:7][63:0]  vsum;
    logic [63:0]       t1;
    logic [63:0]       t2;
    logic [63:0]       w_new;
    logic [6:0]        round;
    logic              busy;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] bsig0(input logic [63:0] x);
        return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
    endfunction

    function automatic logic [63:0] bsig1(input logic [63:0] x);
        return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
    endfunction

    function automatic logic [63:0] ssig0(input logic [63:0] x);
        return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    endfunction

    function automatic logic [63:0] ssig1(input logic [63:0] x);
        return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    endfunction

    // Message schedule kept as a 16-word sliding window: w[0] is W[t] for the current round.
    always_comb begin
        t1      = wv[7] + bsig1(wv[4]) + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + K[round] + w[0];
        t2      = bsig0(wv[0]) + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
        wv_next = {t1 + t2, wv[0], wv[1], wv[2], wv[3] + t1, wv[4], wv[5], wv[6]};
        w_new   = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
        w_next  = {w[1:15], w_new};
        vsum    = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            vsum[i] = hin[i] + wv_next[i];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            w      <= '0;
            hin    <= '0;
            wv     <= '0;
            round  <= '0;
            busy   <= 1'b0;
            o_vout <= '0;
            o_done <= 1'b0;
        end else if (i_start) begin
            w      <= i_data;
            hin    <= i_vin;
            wv     <= i_vin;
            round  <= '0;
            busy   <= 1'b1;
            o_done <= 1'b0;
        end else if (busy) begin
            w  <= w_next;
            wv <= wv_next;
            if (round == 7'd79) begin
                busy   <= 1'b0;
                o_done <= 1'b1;
                o_vout <= vsum;
            end else begin
                round <= round + 7'd1;
            end
        end
    end
endmodule

module sha512_mode_hash #(
    parameter int unsigned CNT_W        = 16,
    parameter logic [1:0]  DEFAULT_MODE = 2'd0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_mode,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1023:0]    i_data,
    input  logic             i_first,
    input  logic             i_last,
    output logic [511:0]     o_digest,
    output logic             o_digest_valid,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_blk_cnt,
    output logic             o_err
);
    typedef enum logic [1:0] {IDLE, START, WAIT, FINAL} state_t;

    state_t        state;
    state_t        next_state;
    logic [1:0]    mode_q;
    logic [511:0]  chain;
    logic [1023:0] data_q;
    logic          last_q;
    logic          chain_open;
    logic          core_start;
    logic          core_rst;
    logic          core_done;
    logic [511:0]  core_vout;
    logic          done_prev;
    logic          done_rise;
    logic          accept;
    logic          drop;

    function automatic logic [511:0] mode_iv(input logic [1:0] m);
        case (m)
            2'd0: return {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                          64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
            2'd1: return {64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
                          64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
            2'd2: return {64'h22312194fc2bf72c, 64'h9f555fa3c84c64c2, 64'h2393b86b6f53b151, 64'h963877195940eabd,
                          64'h96283ee2a88effe3, 64'hbe5e1e2553863992, 64'h2b0199fc2c85b8aa, 64'h0eb72ddc81c52ca2};
            default: return {64'h8c3d37c819544da2, 64'h73e1996689dcd4d6, 64'h1dfab7ae32ff9c82, 64'h679dd514582f9fcf,
                             64'h0f6d2b697bd44da8, 64'h77e36f7304c48942, 64'h3f9d85a86a1d36c8, 64'h1112e6ad91d692a1};
        endcase
    endfunction

    function automatic logic [511:0] mode_mask(input logic [1:0] m);
        case (m)
            2'd0:    return '1;
            2'd1:    return {{384{1'b1}}, {128{1'b0}}};
            2'd2:    return {{256{1'b1}}, {256{1'b0}}};
            default: return {{224{1'b1}}, {288{1'b0}}};
        endcase
    endfunction

    assign core_rst  = ~i_rst_n;
    assign done_rise = core_done & ~done_prev;
    assign o_busy    = chain_open | (state != IDLE);

    sha512_core u_core (
        .i_clk   (i_clk),
        .i_rst   (core_rst),
        .i_start (core_start),
        .i_data  (data_q),
        .i_vin   (chain),
        .o_vout  (core_vout),
        .o_done  (core_done)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        o_ready    = 1'b0;
        accept     = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    if (i_first || chain_open) begin
                        accept     = 1'b1;
                        next_state = START;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            START:   next_state = WAIT;
            WAIT:    if (done_rise) next_state = last_q ? FINAL : IDLE;
            FINAL:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q         <= DEFAULT_MODE;
            chain          <= '0;
            data_q         <= '0;
            last_q         <= 1'b0;
            chain_open     <= 1'b0;
            core_start     <= 1'b0;
            done_prev      <= 1'b0;
            o_blk_cnt      <= '0;
            o_digest       <= '0;
            o_digest_valid <= 1'b0;
            o_err          <= 1'b0;
        end else begin
            core_start     <= (next_state == START);
            done_prev      <= core_done;
            o_digest_valid <= 1'b0;
            o_err          <= drop;
            if (accept) begin
                data_q <= i_data;
                last_q <= i_last;
                if (i_first) begin
                    mode_q    <= i_mode;
                    chain     <= mode_iv(i_mode);
                    o_blk_cnt <= '0;
                end
            end
            // Digest is taken straight from the core result on the WAIT->FINAL edge,
            // so o_digest and o_digest_valid are both presented during the FINAL cycle.
            if (state == WAIT && done_rise) begin
                chain <= core_vout;
                if (o_blk_cnt != '1) o_blk_cnt <= o_blk_cnt + CNT_W'(1);
                if (last_q) begin
                    o_digest       <= core_vout & mode_mask(mode_q);
                    o_digest_valid <= 1'b1;
                end else begin
                    chain_open <= 1'b1;
                end
            end
            if (state == FINAL) chain_open <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sha512_mode_hash.sv
// Self-checking bench for sha512_mode_hash: known-answer vectors, protocol corner cases,
// and random multi-block messages checked against a FIPS 180-4 reference model.

module tb_sha512_mode_hash;
    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic [1:0]    i_mode;
    logic          i_valid;
    logic          o_ready;
    logic [1023:0] i_data;
    logic          i_first;
    logic          i_last;
    logic [511:0]  o_digest;
    logic          o_digest_valid;
    logic          o_busy;
    logic [15:0]   o_blk_cnt;
    logic          o_err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    logic [511:0] iv_tab [4];

    localparam logic [63:0] KT [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    localparam logic [511:0] IV512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    localparam logic [511:0] IV384 = {
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};

    localparam logic [511:0] KAT384_ABC = {384'hcb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7, 128'h0};
    localparam logic [511:0] KAT384_DIG = {384'h8deb7dccae68efbafec82d5a3d9d851aef458bc27ffcc0fcc8cc0e43b7620eb14865b0d675dbbf9230548528b47ffe7b, 128'h0};
    localparam logic [511:0] KAT512_ABC = 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
    localparam logic [511:0] KAT256_ABC = {256'h53048e2681941ef99b2e29b76b4c7dabe4c2d0c634fc6d46e0e2f13107e7af23, 256'h0};

    always #5 i_clk = ~i_clk;

    sha512_mode_hash #(.CNT_W(16), .DEFAULT_MODE(2'd0)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_mode         (i_mode),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_data         (i_data),
        .i_first        (i_first),
        .i_last         (i_last),
        .o_digest       (o_digest),
        .o_digest_valid (o_digest_valid),
        .o_busy         (o_busy),
        .o_blk_cnt      (o_blk_cnt),
        .o_err          (o_err)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Straight FIPS 180-4 compression with the full 80-word schedule.
    function automatic logic [511:0] ref_compress(input logic [511:0] hv, input logic [1023:0] blk);
        logic [63:0] w [80];
        logic [63:0] v [8];
        logic [63:0] t1;
        logic [63:0] t2;
        logic [511:0] res;
        for (int t = 0; t < 16; t++) w[t] = blk[1023 - 64*t -: 64];
        for (int t = 16; t < 80; t++)
            w[t] = (ror(w[t-2], 19) ^ ror(w[t-2], 61) ^ (w[t-2] >> 6)) + w[t-7]
                 + (ror(w[t-15], 1) ^ ror(w[t-15], 8) ^ (w[t-15] >> 7)) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = hv[511 - 64*i -: 64];
        for (int t = 0; t < 80; t++) begin
            t1 = v[7] + (ror(v[4], 14) ^ ror(v[4], 18) ^ ror(v[4], 41))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (ror(v[0], 28) ^ ror(v[0], 34) ^ ror(v[0], 39))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[511 - 64*i -: 64] = hv[511 - 64*i -: 64] + v[i];
        return res;
    endfunction

    task automatic pad_msg(input byte unsigned msg[$], output logic [1023:0] blks[$]);
        int unsigned   len;
        int unsigned   total;
        logic [63:0]   bitlen;
        logic [7:0]    b;
        logic [1023:0] blk;
        len    = msg.size();
        total  = ((len + 17 + 127) / 128) * 128;
        bitlen = 64'(len) * 64'd8;
        blks.delete();
        blk = '0;
        for (int unsigned i = 0; i < total; i++) begin
            if (i < len)             b = msg[i];
            else if (i == len)       b = 8'h80;
            else if (i >= total - 8) b = 8'(bitlen >> (8 * (total - 1 - i)));
            else                     b = 8'h00;
            blk[1023 - 8*(i % 128) -: 8] = b;
            if (i % 128 == 127) blks.push_back(blk);
        end
    endtask

    task automatic str_bytes(input string s, output byte unsigned q[$]);
        q.delete();
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endtask

    function automatic logic [511:0] ref_digest(input logic [1:0] mode, input logic [1023:0] blks[$]);
        logic [511:0] h;
        int           keep;
        h = iv_tab[mode];
        foreach (blks[i]) h = ref_compress(h, blks[i]);
        keep = (mode == 2'd0) ? 512 : (mode == 2'd1) ? 384 : (mode == 2'd2) ? 256 : 224;
        return (h >> (512 - keep)) << (512 - keep);
    endfunction

    function automatic logic [1023:0] rand_block();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Drives one message; i_valid stays high from the first block until the last is accepted.
    task automatic send_msg(input logic [1:0] mode, input logic [1:0] later_mode,
                            input logic [1023:0] blks[$], input bit close,
                            output logic [511:0] dig, output logic [15:0] cnt);
        int guard;
        for (int b = 0; b < blks.size(); b++) begin
            @(negedge i_clk);
            i_valid = 1'b1;
            i_data  = blks[b];
            i_first = (b == 0);
            i_last  = close && (b == blks.size() - 1);
            i_mode  = (b == 0) ? mode : later_mode;
            guard = 0;
            while (!o_ready && guard < 400) begin
                @(negedge i_clk);
                guard++;
            end
            check("accept_in_time", 512'(guard < 400), 512'd1);
            @(posedge i_clk);
            #1;
            if (b == blks.size() - 1) i_valid = 1'b0;
            check("ready_low_start", 512'(o_ready), 512'd0);
            check("busy_start", 512'(o_busy), 512'd1);
            @(posedge i_clk);
            #1;
            check("ready_low_wait", 512'(o_ready), 512'd0);
        end
        dig = '0;
        cnt = '0;
        guard = 0;
        if (close) begin
            while (!o_digest_valid && guard < 400) begin
                @(negedge i_clk);
                guard++;
            end
            check("digest_in_time", 512'(guard < 400), 512'd1);
            dig = o_digest;
            cnt = o_blk_cnt;
            @(negedge i_clk);
            check("digest_valid_pulse", 512'(o_digest_valid), 512'd0);
            check("busy_after_final", 512'(o_busy), 512'd0);
        end else begin
            while (!o_ready && guard < 400) begin
                @(negedge i_clk);
                guard++;
            end
            check("chain_done_in_time", 512'(guard < 400), 512'd1);
            cnt = o_blk_cnt;
            check("busy_chain_open", 512'(o_busy), 512'd1);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte unsigned  mb [$];
        logic [1023:0] q_abc [$];
        logic [1023:0] q_two [$];
        logic [1023:0] q_a [$];
        logic [1023:0] q_b [$];
        logic [511:0]  dig;
        logic [15:0]   cnt;
        logic [1:0]    mode;
        int unsigned   nb;
        bit            seen_dv;
        bit            seen_busy;

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_mode  = 2'd0;
        i_data  = '0;
        i_first = 1'b0;
        i_last  = 1'b0;

        iv_tab[0] = IV512;
        iv_tab[1] = IV384;
        str_bytes("SHA-512/256", mb);
        pad_msg(mb, q_a);
        iv_tab[2] = ref_compress(IV512 ^ {8{64'ha5a5a5a5a5a5a5a5}}, q_a[0]);
        str_bytes("SHA-512/224", mb);
        pad_msg(mb, q_a);
        iv_tab[3] = ref_compress(IV512 ^ {8{64'ha5a5a5a5a5a5a5a5}}, q_a[0]);

        str_bytes("abc", mb);
        pad_msg(mb, q_abc);
        mb.delete();
        for (int i = 0; i < 160; i++) mb.push_back(8'(8'h30 + (i + 1) % 10));
        pad_msg(mb, q_two);

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_digest", o_digest, '0);
        check("rst_dv", 512'(o_digest_valid), 512'd0);
        check("rst_err", 512'(o_err), 512'd0);
        check("rst_cnt", 512'(o_blk_cnt), 512'd0);
        check("rst_busy", 512'(o_busy), 512'd0);
        check("rst_ready", 512'(o_ready), 512'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Protocol error straight after reset
        @(negedge i_clk);
        i_valid = 1'b1;
        i_first = 1'b0;
        i_last  = 1'b1;
        i_data  = rand_block();
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        check("err_pulse", 512'(o_err), 512'd1);
        check("err_busy", 512'(o_busy), 512'd0);
        check("err_ready", 512'(o_ready), 512'd1);
        @(posedge i_clk);
        #1;
        check("err_clear", 512'(o_err), 512'd0);
        seen_dv = 0;
        seen_busy = 0;
        repeat (100) begin
            @(negedge i_clk);
            seen_dv   |= o_digest_valid;
            seen_busy |= o_busy;
        end
        check("err_no_digest", 512'(seen_dv), 512'd0);
        check("err_no_busy", 512'(seen_busy), 512'd0);
        check("err_cnt", 512'(o_blk_cnt), 512'd0);

        // SHA-384 "abc" using the literal padded block
        q_a.delete();
        q_a.push_back({32'h61626380, 960'h0, 32'h00000018});
        check("pad_abc_block", q_abc[0], q_a[0]);
        send_msg(2'd1, 2'd1, q_a, 1'b1, dig, cnt);
        check("sha384_abc", dig, KAT384_ABC);
        check("sha384_abc_cnt", 512'(cnt), 512'd1);

        // SHA-384 two-block message
        send_msg(2'd1, 2'd1, q_two, 1'b1, dig, cnt);
        check("sha384_two", dig, KAT384_DIG);
        check("sha384_two_cnt", 512'(cnt), 512'd2);

        // SHA-512 and SHA-512/256 "abc"
        send_msg(2'd0, 2'd0, q_abc, 1'b1, dig, cnt);
        check("sha512_abc", dig, KAT512_ABC);
        send_msg(2'd2, 2'd2, q_abc, 1'b1, dig, cnt);
        check("sha512_256_abc", dig, KAT256_ABC);
        check("model_256_abc", ref_digest(2'd2, q_abc), KAT256_ABC);

        // i_mode ignored on continuation blocks
        send_msg(2'd1, 2'd0, q_two, 1'b1, dig, cnt);
        check("mode_change_mid", dig, KAT384_DIG);

        // Continuation with no open chain after a completed message
        @(negedge i_clk);
        i_valid = 1'b1;
        i_first = 1'b0;
        i_last  = 1'b0;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        check("err_closed_chain", 512'(o_err), 512'd1);
        check("err_keeps_cnt", 512'(o_blk_cnt), 512'd2);

        // Open chain abandoned by a new first block
        q_a.delete();
        q_a.push_back(rand_block());
        send_msg(2'd3, 2'd3, q_a, 1'b0, dig, cnt);
        check("open_chain_cnt", 512'(cnt), 512'd1);
        q_b.delete();
        q_b.push_back(rand_block());
        q_b.push_back(rand_block());
        send_msg(2'd3, 2'd1, q_b, 1'b1, dig, cnt);
        check("restart_digest", dig, ref_digest(2'd3, q_b));
        check("restart_cnt", 512'(cnt), 512'd2);

        // Async reset during WAIT of block 1 of 2
        @(negedge i_clk);
        i_valid = 1'b1;
        i_first = 1'b1;
        i_last  = 1'b0;
        i_mode  = 2'd1;
        i_data  = q_two[0];
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (20) @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("midrst_digest", o_digest, '0);
        check("midrst_busy", 512'(o_busy), 512'd0);
        check("midrst_cnt", 512'(o_blk_cnt), 512'd0);
        check("midrst_ready", 512'(o_ready), 512'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        seen_dv = 0;
        seen_busy = 0;
        repeat (150) begin
            @(negedge i_clk);
            seen_dv   |= o_digest_valid;
            seen_busy |= o_busy;
        end
        check("midrst_no_digest", 512'(seen_dv), 512'd0);
        check("midrst_idle", 512'(seen_busy), 512'd0);
        q_a.delete();
        q_a.push_back({32'h61626380, 960'h0, 32'h00000018});
        send_msg(2'd1, 2'd1, q_a, 1'b1, dig, cnt);
        check("post_rst_abc", dig, KAT384_ABC);
        check("post_rst_cnt", 512'(cnt), 512'd1);

        // Random messages, all modes
        for (int m = 0; m < 8; m++) begin
            mode = 2'($urandom_range(3));
            nb   = $urandom_range(1, 3);
            q_a.delete();
            for (int unsigned k = 0; k < nb; k++) q_a.push_back(rand_block());
            send_msg(mode, 2'($urandom_range(3)), q_a, 1'b1, dig, cnt);
            check("rand_digest", dig, ref_digest(mode, q_a));
            check("rand_cnt", 512'(cnt), 512'(nb));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sha512_mode_hash.md
Name: sha512_mode_hash

Overview:
- Multi-mode, multi-block hash controller for the SHA-512 family: SHA-512, SHA-384, SHA-512/256 and SHA-512/224.
- Wraps one sha512_core instance (ports i_clk, i_rst, i_start, i_data[1023:0], i_vin[511:0], o_vout[511:0], o_done).
- Selects the mode IV, chains pre-padded 1024-bit blocks through the core, and truncates/masks the final digest.
- Sits between the message-padding front end and the digest consumer. Removes IV and chaining handling from upper layers.

Parameters:
CNT_W, 16, width of the block counter o_blk_cnt (saturating).
DEFAULT_MODE, 2'd0, mode value loaded into the mode register at reset.

Ports:
i_clk  input  1  system clock, rising edge.
i_rst_n  input  1  reset, asynchronous assert, active-low.
i_mode  input  2  0=SHA-512, 1=SHA-384, 2=SHA-512/256, 3=SHA-512/224. Sampled only on an accepted first block.
i_valid  input  1  block present on i_data.
o_ready  output  1  controller can accept a block.
i_data  input  1024  pre-padded message block, big-endian, word0 in [1023:960].
i_first  input  1  block is the first of a message.
i_last  input  1  block is the last of a message (first and last may both be 1).
o_digest  output  512  final digest, left-aligned. Bits beyond the mode length are 0.
o_digest_valid  output  1  one-cycle pulse; o_digest is valid.
o_busy  output  1  message in progress: chain open, or a block is being processed.
o_blk_cnt  output  CNT_W  blocks compressed in the current or last message.
o_err  output  1  one-cycle pulse; a protocol-violation block was dropped.

Behaviour:
Reset:
- Asynchronous on i_rst_n=0. The core receives i_rst = ~i_rst_n.
- All of the following clear to 0: o_digest, o_digest_valid, o_err, o_blk_cnt, o_busy, the chain register, chain_open and the core i_start.
- FSM returns to IDLE. o_ready is 1 in IDLE after reset. mode_q = DEFAULT_MODE.
- Reset mid-operation discards the message. No digest or error pulse is produced.

FSM states: IDLE, START, WAIT, FINAL.

IDLE:
- o_ready=1. A block is accepted when i_valid & o_ready.
- Accepted with i_first=1:
  - mode_q <= i_mode.
  - chain <= IV(i_mode), per FIPS 180-4 §5.3.4-5.3.6. First words: 6a09e667f3bcc908, cbbb9d5dc1059ed8, 22312194fc2bf72c, 8c3d37c819544da2.
  - o_blk_cnt <= 0.
  - This restarts any open chain; the earlier message is abandoned silently.
- Accepted with i_first=0 and chain_open=1: the block continues the chain. i_mode is ignored.
- Accepted with i_first=0 and chain_open=0: block dropped, o_err pulses 1 cycle, stay in IDLE.
- On every non-dropped accept: data_q <= i_data, last_q <= i_last, go to START.

START:
- One cycle. Core i_start=1 with i_vin=chain and i_data=data_q.
- o_ready=0. Go to WAIT.

WAIT:
- o_ready=0. Wait for a rising edge of core o_done. A previously held-high done level is not a completion.
- On completion:
  - chain <= o_vout.
  - o_blk_cnt increments, saturating at all-ones.
  - last_q=1: go to FINAL.
  - Otherwise: chain_open <= 1, go to IDLE.
- Latency per block: accept → START 1 cycle, then core latency, then 1 cycle to register.

FINAL:
- o_digest <= chain AND mask(mode_q). o_digest_valid=1 for exactly this cycle.
- Masks keep: SHA-512 [511:0]; SHA-384 [511:128]; SHA-512/256 [511:256]; SHA-512/224 [511:288].
- chain_open <= 0, go to IDLE.
- o_digest holds its value until the next FINAL or reset.

Other rules:
- o_busy = chain_open | (state != IDLE).
- Back-to-back blocks: the next accept may occur in the cycle immediately after returning to IDLE.

Test Plan:
1. SHA-384 "abc": mode=1, first=last=1, block {61626380, 960'h0, 00000018} → single digest_valid. o_digest[511:128]=cb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7, [127:0]=0, blk_cnt=1.
2. SHA-384, 160-digit "1234567890"×16: two blocks (first, then last) with i_valid held across the busy period → digest 8deb7dccae68efbafec82d5a3d9d851aef458bc27ffcc0fcc8cc0e43b7620eb14865b0d675dbbf9230548528b47ffe7b, blk_cnt=2, o_ready low during START/WAIT.
3. SHA-512 "abc" (mode=0), then SHA-512/256 "abc" (mode=2) → ddaf35a193617aba…a54ca49f (full 512). Then 53048e2681941ef99b2e29b76b4c7dabe4c2d0c634fc6d46e0e2f13107e7af23 in [511:256], low bits 0.
4. Mode change mid-chain: first block mode=1, second block i_mode=0 with i_first=0 → result equals scenario 2 (mode_q unchanged).
5. Protocol error: i_valid with i_first=0 after reset → o_err 1-cycle pulse, no core start, o_busy=0, o_blk_cnt=0.
6. Async reset asserted during WAIT of block 1 of 2 → outputs 0 immediately, no digest_valid. A subsequent scenario-1 run passes unchanged.
